uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8-bit frame, parity, stop bit) between NUM_REQ byte producers, e.g. a command responder, a status reporter and a debug logger.
- Selects one pending requester, hands its byte to the transmitter with a one-cycle start strobe, then holds ownership until the transmitter reports frame completion.
- Sits between the producers and the transmitter, on the same clock as the UART datapath.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- DATA_W, 8, byte width, matches the UART data field.
- TIMEOUT_CYC, 4096, maximum cycles in WAIT_DONE before ownership is forcibly released.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester byte pending.
- req_data  input  NUM_REQ*DATA_W  packed bytes; requester i at bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester.
- tx_o_start  output  1  one-cycle start strobe to the transmitter.
- tx_o_data  output  DATA_W  byte to transmit; held stable from start until done.
- tx_i_busy  input  1  transmitter occupied.
- tx_i_done  input  1  one-cycle pulse at the end of the stop bit.
- arb_o_owner  output  $clog2(NUM_REQ)  index of the current or last owner.
- arb_o_active  output  1  high in START and WAIT_DONE.
- arb_o_timeout  output  1  one-cycle pulse when a timeout release occurs.

Behaviour:
- Reset (async assert, sync deassert by the user):
  - All outputs 0; state IDLE; round-robin pointer 0; timeout counter 0.
  - Reset mid-frame clears tx_o_start and req_ready immediately. No grant is remembered across reset.
- States: IDLE, START, WAIT_DONE. All outputs are registered.
- IDLE:
  - Grant only when tx_i_busy=0 and any req_valid=1.
  - Winner is the first asserted req_valid searching from pointer upward, with wrap-around from NUM_REQ-1 to 0.
  - Next cycle: state=START, arb_o_owner=winner, tx_o_data=winner's req_data, tx_o_start=1, req_ready[winner]=1, arb_o_active=1.
  - Latency: req_valid sampled at edge n gives tx_o_start high in cycle n+1.
- START: lasts exactly one cycle.
  - tx_o_start and req_ready drop.
  - pointer=(winner+1) mod NUM_REQ.
  - Go to WAIT_DONE with counter cleared.
- WAIT_DONE:
  - tx_o_data held.
  - Counter increments each cycle.
  - tx_i_done=1 -> IDLE.
  - Else counter==TIMEOUT_CYC-1 -> pulse arb_o_timeout, go to IDLE.
  - tx_i_done and timeout in the same cycle: done wins, no timeout pulse.
- Leaving WAIT_DONE: arb_o_active drops in the cycle the state returns to IDLE. A new grant can start no earlier than the cycle after IDLE is entered, giving a minimum 1-cycle gap.
- Handshake rules:
  - Requester holds req_valid and req_data until it sees req_ready.
  - Deasserting req_valid before grant is legal and loses no arbitration state.
  - req_valid asserted for the current owner during WAIT_DONE waits for the next arbitration, where it has lowest priority.
- tx_i_done outside WAIT_DONE is ignored.
- tx_i_busy is ignored outside IDLE.
- NUM_REQ=1: pointer is constant 0.

Optional Feature:
- UART_ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted index always wins; pointer is not updated.
- Undefined (default): round-robin as described above.
- All ports are identical in both builds.

Test Plan:
- Single request: req_valid=4'b0100, req_data[2]=8'hCE -> next cycle tx_o_start=1, tx_o_data=8'hCE, req_ready=4'b0100, arb_o_owner=2. tx_i_done 100 cycles later -> IDLE, arb_o_active=0.
- Round-robin: all four valid, bytes 8'hA0..8'hA3, done pulsed after each start -> grant order 0,1,2,3,0; pointer wraps.
- Busy gating: tx_i_busy=1 with req_valid=4'b0001 -> no tx_o_start. tx_i_busy falls -> tx_o_start one cycle later with 8'hAA.
- Timeout: TIMEOUT_CYC=16, grant requester 1, never pulse tx_i_done -> arb_o_timeout pulses after 16 WAIT_DONE cycles; next grant goes to requester 2 if valid.
- Done/timeout collision: tx_i_done on the final timeout cycle -> arb_o_timeout stays 0, clean return to IDLE.
- Async reset mid-frame: assert rst_n=0 in WAIT_DONE -> all outputs 0 immediately. After release, req_valid=4'b1010 grants requester 1 (pointer reset to 0). With UART_ARB_FIXED_PRIO_EN, repeated all-valid rounds always grant 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte producers. One pending
//   requester is picked, its byte is handed over with a one-cycle start
//   strobe, and ownership is held until the transmitter reports the end of
//   the frame (or a timeout forces the arbiter to give it up).
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   req_valid      per-requester byte pending
//   req_data       packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_ready      one-cycle accept pulse to the granted requester
//   tx_o_start     one-cycle start strobe to the transmitter
//   tx_o_data      byte being sent, stable from start until release
//   tx_i_busy      transmitter occupied (only looked at in IDLE)
//   tx_i_done      end-of-frame pulse (only looked at in WAIT_DONE)
//   arb_o_owner    index of the current or last owner
//   arb_o_active   high in START and WAIT_DONE
//   arb_o_timeout  one-cycle pulse on a forced release
//
// Build option
//   UART_ARB_FIXED_PRIO_EN  lowest asserted index always wins and the
//                           round-robin pointer stays at 0.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no owner; grant when transmitter free and a request pending
// START     | single cycle: start strobe and req_ready out, pointer advances
// WAIT_DONE | owner holds the transmitter; counting towards timeout

module uart_tx_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = 8,
  parameter  int TIMEOUT_CYC = 4096,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_o_start,
  output logic [DATA_W-1:0]         tx_o_data,
  input  logic                      tx_i_busy,
  input  logic                      tx_i_done,
  output logic [IDX_W-1:0]          arb_o_owner,
  output logic                      arb_o_active,
  output logic                      arb_o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_owner;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_start;
  logic [NUM_REQ-1:0]  r_ready;
  logic [DATA_W-1:0]   r_data;
  logic                r_active;
  logic                r_timeout;

  logic                w_any;
  logic [IDX_W-1:0]    w_winner;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic [DATA_W-1:0]   w_win_data;

  // Search upward from the pointer with wrap-around. In the fixed-priority
  // build the pointer never leaves 0, so this degenerates to lowest-index-wins.
  always_comb begin : p_pick
    int idx;
    idx        = 0;
    w_any      = 1'b0;
    w_winner   = '0;
    w_grant_oh = '0;
    w_win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_any && req_valid[idx]) begin
        w_any           = 1'b1;
        w_winner        = IDX_W'(idx);
        w_grant_oh[idx] = 1'b1;
        w_win_data      = req_data[idx*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_ready   <= '0;
      r_data    <= '0;
      r_active  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_start   <= 1'b0;
      r_ready   <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!tx_i_busy && w_any) begin
            r_state  <= S_START;
            r_owner  <= w_winner;
            r_data   <= w_win_data;
            r_start  <= 1'b1;
            r_ready  <= w_grant_oh;
            r_active <= 1'b1;
          end
        end
        S_START: begin
`ifdef UART_ARB_FIXED_PRIO_EN
          r_ptr <= '0;
`else
          // The owner drops to lowest priority for the next arbitration.
          if (r_owner == IDX_W'(NUM_REQ - 1)) r_ptr <= '0;
          else                                 r_ptr <= r_owner + 1'b1;
`endif
          r_cnt   <= '0;
          r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // A done pulse on the last allowed cycle is a normal completion.
          if (tx_i_done) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            r_state   <= S_IDLE;
            r_active  <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready     = r_ready;
  assign tx_o_start    = r_start;
  assign tx_o_data     = r_data;
  assign arb_o_owner   = r_owner;
  assign arb_o_active  = r_active;
  assign arb_o_timeout = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: randomized requesters and transmitter
// against a queue/array reference model, checked by a separate monitor.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            tx_o_start;
  logic [DW-1:0]   tx_o_data;
  logic            tx_i_busy;
  logic            tx_i_done;
  logic [1:0]      arb_o_owner;
  logic            arb_o_active;
  logic            arb_o_timeout;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_o_start(tx_o_start), .tx_o_data(tx_o_data),
    .tx_i_busy(tx_i_busy), .tx_i_done(tx_i_done),
    .arb_o_owner(arb_o_owner), .arb_o_active(arb_o_active),
    .arb_o_timeout(arb_o_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; int owner; int data; } start_t;
  typedef struct { int cyc; bit to; } end_t;
  start_t exp_q[$];
  end_t   end_q[$];

  // Reference model state
  bit       pend [NR];
  logic [7:0] pdata [NR];
  int       m_ptr = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = pend[i];
      req_data[i*DW +: DW] = pdata[i];
    end
  endtask

  function automatic int pick();
    int i;
    for (int k = 0; k < NR; k++) begin
      i = (m_ptr + k) % NR;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic add_random_reqs();
    int n;
    n = 0;
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && $urandom_range(0, 1) == 1) begin
        pend[i]  = 1'b1;
        pdata[i] = 8'($urandom);
      end
      if (pend[i]) n++;
    end
    if (n == 0) begin
      n = $urandom_range(0, NR - 1);
      pend[n]  = 1'b1;
      pdata[n] = 8'($urandom);
    end
    drive_reqs();
  endtask

  function automatic int num_pend();
    int n;
    n = 0;
    for (int i = 0; i < NR; i++) if (pend[i]) n++;
    return n;
  endfunction

  // Entered at a falling edge with the arbiter idle; leaves at the falling
  // edge of the first idle cycle after release, with tx_i_busy high.
  task automatic run_txn(input int idle_n, input int d, input bit spur, input bit rereq);
    int w, c, i, n_wait;
    tx_i_busy = 1'b1;
    tx_i_done = 1'b0;
    drive_reqs();
    for (int k = 0; k < idle_n; k++) begin
      @(negedge clk);
      tx_i_done = spur && (k == 0);
      if ($urandom_range(0, 3) == 0 && num_pend() > 1) begin
        i = $urandom_range(0, NR - 1);
        pend[i] = 1'b0;
        drive_reqs();
      end
    end
    tx_i_done = 1'b0;
    w = pick();
    c = cyc;
    exp_q.push_back('{cyc: c + 1, owner: w, data: int'(pdata[w])});
    tx_i_busy = 1'b0;
    @(negedge clk);
    pend[w] = 1'b0;
    drive_reqs();
`ifndef UART_ARB_FIXED_PRIO_EN
    m_ptr = (w + 1) % NR;
`endif
    tx_i_busy = 1'($urandom_range(0, 1));
    tx_i_done = spur;
    if (d < TO) begin
      end_q.push_back('{cyc: c + 3 + d, to: 1'b0});
      n_wait = d + 1;
    end else begin
      end_q.push_back('{cyc: c + 2 + TO, to: 1'b1});
      n_wait = TO;
    end
    for (int j = 0; j < n_wait; j++) begin
      @(negedge clk);
      tx_i_busy = 1'($urandom_range(0, 1));
      tx_i_done = (j == d);
      if (j == 0 && rereq) begin
        pend[w]  = 1'b1;
        pdata[w] = 8'($urandom);
        drive_reqs();
      end
    end
    @(negedge clk);
    tx_i_done = 1'b0;
    tx_i_busy = 1'b1;
  endtask

  // Monitor / scoreboard
  bit prev_act = 1'b0;
  int hold_data = 0;
  always @(negedge clk) begin : mon
    start_t s;
    end_t   e;
    if (!rst_n) begin
      prev_act = 1'b0;
    end else begin
      if (tx_o_start) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          s = exp_q.pop_front();
          chk("start_cycle", cyc, s.cyc);
          chk("owner", int'(arb_o_owner), s.owner);
          chk("tx_data", int'(tx_o_data), s.data);
          chk("req_ready", int'(req_ready), 1 << s.owner);
          chk("active_at_start", int'(arb_o_active), 1);
          hold_data = s.data;
        end
      end else begin
        chk("ready_quiet", int'(req_ready), 0);
        if (arb_o_active) chk("data_hold", int'(tx_o_data), hold_data);
      end
      if (prev_act && !arb_o_active) begin
        if (end_q.size() == 0) begin
          chk("unexpected_release", 1, 0);
        end else begin
          e = end_q.pop_front();
          chk("release_cycle", cyc, e.cyc);
          chk("timeout_pulse", int'(arb_o_timeout), int'(e.to));
        end
      end else begin
        chk("stray_timeout", int'(arb_o_timeout), 0);
      end
      prev_act = arb_o_active;
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_start"},   int'(tx_o_start), 0);
    chk({tag, "_ready"},   int'(req_ready), 0);
    chk({tag, "_data"},    int'(tx_o_data), 0);
    chk({tag, "_owner"},   int'(arb_o_owner), 0);
    chk({tag, "_active"},  int'(arb_o_active), 0);
    chk({tag, "_timeout"}, int'(arb_o_timeout), 0);
  endtask

  initial begin
    int w;
    rst_n     = 1'b1;
    tx_i_busy = 1'b1;
    tx_i_done = 1'b0;
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; pdata[i] = 8'h00; end
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin: all four valid, owner 0 re-requests while it owns the line
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b1; pdata[i] = 8'(8'hA0 + i); end
    run_txn(0, 3, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) run_txn(0, 2 + r, 1'b0, 1'b0);

    // Single request on requester 2
    pend[2] = 1'b1; pdata[2] = 8'hCE;
    run_txn(2, 5, 1'b1, 1'b0);

    // Busy gating: transmitter busy for several cycles first
    pend[0] = 1'b1; pdata[0] = 8'hAA;
    run_txn(6, 4, 1'b1, 1'b0);

    // Timeout on requester 1, then 0 and 2 both pending
    pend[1] = 1'b1; pdata[1] = 8'h5A;
    run_txn(0, TO + 3, 1'b0, 1'b0);
    pend[0] = 1'b1; pdata[0] = 8'h10;
    pend[2] = 1'b1; pdata[2] = 8'h12;
    run_txn(0, 1, 1'b0, 1'b0);

    // Done on the final timeout cycle
    run_txn(1, TO - 1, 1'b0, 1'b0);
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;

    // Async reset while in WAIT_DONE
    pend[3] = 1'b1; pdata[3] = 8'h33;
    drive_reqs();
    w = pick();
    exp_q.push_back('{cyc: cyc + 1, owner: w, data: int'(pdata[w])});
    tx_i_busy = 1'b0;
    @(negedge clk);
    pend[w] = 1'b0;
    drive_reqs();
    tx_i_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midframe_reset");
    m_ptr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pend[1] = 1'b1; pdata[1] = 8'h61;
    pend[3] = 1'b1; pdata[3] = 8'h63;
    run_txn(0, 2, 1'b0, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      add_random_reqs();
      run_txn($urandom_range(0, 3), $urandom_range(0, TO + 3),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("starts_outstanding", exp_q.size(), 0);
    chk("releases_outstanding", end_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
